// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the muldiv_seq sequencer: ALU opcodes, MD operation codes, FSM states.
package muldiv_seq_pkg;

    localparam logic [4:0] ALUOP_NOP  = 5'd0;
    localparam logic [4:0] ALUOP_ADDU = 5'd1;
    localparam logic [4:0] ALUOP_SUBU = 5'd2;

    // op[1] selects divide, op[0] selects unsigned
    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StPrep,
        StIter,
        StFixup,
        StDone
    } md_state_e;

    function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer driving a shared external ALU; owns HI/LO.
// Optional MTHI/MTLO write ports are enabled by defining MULDIV_HILO_WR_EN.
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned ALUOP_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [1:0]         op_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [WIDTH-1:0]   alu_a_o,
    output logic [WIDTH-1:0]   alu_b_o,
    output logic [ALUOP_W-1:0] alu_op_o,
    input  logic [WIDTH-1:0]   alu_c_i,
    output logic               busy_o,
    output logic               done_o,
`ifdef MULDIV_HILO_WR_EN
    input  logic               hi_we_i,
    input  logic               lo_we_i,
    input  logic [WIDTH-1:0]   wdata_i,
`endif
    output logic [WIDTH-1:0]   hi_o,
    output logic [WIDTH-1:0]   lo_o
);

    md_state_e         state_q;
    logic [1:0]        op_q;
    logic [WIDTH-1:0]  a_q, b_q;
    logic [WIDTH-1:0]  opnd_q;
    logic [WIDTH-1:0]  acc_hi_q, acc_lo_q;
    logic [4:0]        cnt_q;
    logic              neg_quo_q, neg_rem_q;
    logic [WIDTH-1:0]  hi_q, lo_q;
    logic              busy_q, done_q;

    logic              is_signed;
    logic [WIDTH-1:0]  a_abs, b_abs;
    logic              carry, take;
    logic [63:0]       prod, prod_neg;

    assign is_signed = ~op_q[0];
    assign a_abs     = abs32(a_q, is_signed);
    assign b_abs     = abs32(b_q, is_signed);
    assign prod      = {acc_hi_q, acc_lo_q};
    assign prod_neg  = ~prod + 64'd1;

    always_comb begin
        alu_a_o  = '0;
        alu_b_o  = '0;
        alu_op_o = ALUOP_W'(ALUOP_NOP);
        if (state_q == StIter) begin
            if (op_q[1]) begin
                alu_a_o  = {acc_hi_q[WIDTH-2:0], acc_lo_q[WIDTH-1]};
                alu_b_o  = opnd_q;
                alu_op_o = ALUOP_W'(ALUOP_SUBU);
            end else begin
                alu_a_o  = acc_hi_q;
                alu_b_o  = acc_lo_q[0] ? opnd_q : '0;
                alu_op_o = ALUOP_W'(ALUOP_ADDU);
            end
        end
    end

    // A 33-bit partial remainder whose top bit fell out of alu_a_o always exceeds the divisor
    assign carry = (alu_c_i < alu_a_o);
    assign take  = acc_hi_q[WIDTH-1] | (alu_a_o >= opnd_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            op_q      <= MD_MULT;
            a_q       <= '0;
            b_q       <= '0;
            opnd_q    <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
`ifdef MULDIV_HILO_WR_EN
            if (state_q == StIdle || state_q == StDone) begin
                if (hi_we_i) hi_q <= wdata_i;
                if (lo_we_i) lo_q <= wdata_i;
            end
`endif
            case (state_q)
                StIdle, StDone: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        op_q    <= op_i;
                        a_q     <= a_i;
                        b_q     <= b_i;
                        busy_q  <= 1'b1;
                        state_q <= StPrep;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StPrep: begin
                    neg_quo_q <= is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                    neg_rem_q <= is_signed & a_q[WIDTH-1];
                    acc_hi_q  <= '0;
                    cnt_q     <= '0;
                    if (op_q[1]) begin
                        acc_lo_q <= a_abs;
                        opnd_q   <= b_abs;
                        if (b_q == '0) begin
                            lo_q    <= '1;
                            hi_q    <= a_q;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            state_q <= StIter;
                        end
                    end else begin
                        acc_lo_q <= b_abs;
                        opnd_q   <= a_abs;
                        state_q  <= StIter;
                    end
                end
                StIter: begin
                    if (op_q[1]) begin
                        acc_hi_q <= take ? alu_c_i : alu_a_o;
                        acc_lo_q <= {acc_lo_q[WIDTH-2:0], take};
                    end else begin
                        acc_hi_q <= {carry, alu_c_i[WIDTH-1:1]};
                        acc_lo_q <= {alu_c_i[0], acc_lo_q[WIDTH-1:1]};
                    end
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) state_q <= StFixup;
                end
                StFixup: begin
                    if (op_q[1]) begin
                        lo_q <= neg_quo_q ? (~acc_lo_q + 32'd1) : acc_lo_q;
                        hi_q <= neg_rem_q ? (~acc_hi_q + 32'd1) : acc_hi_q;
                    end else begin
                        {hi_q, lo_q} <= neg_quo_q ? prod_neg : prod;
                    end
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= StDone;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule
